// File: rtl/bsg_test_node_pkg.sv
// Shared field layout, command opcodes and control-state type for the
// ring test-node echo client.
package bsg_test_node_pkg;

  localparam int unsigned destid_width_lp  = 4;
  localparam int unsigned cmd_width_lp     = 1;
  localparam int unsigned opcode_width_lp  = 7;
  localparam int unsigned header_width_lp  = destid_width_lp + cmd_width_lp + opcode_width_lp;

  localparam logic [opcode_width_lp-1:0] cmd_enable  = 7'h01;
  localparam logic [opcode_width_lp-1:0] cmd_disable = 7'h02;
  localparam logic [opcode_width_lp-1:0] cmd_clear   = 7'h03;

  typedef enum logic {
    DISABLED = 1'b0,
    ENABLED  = 1'b1
  } state_e;

endpackage

// File: rtl/bsg_test_node_resp_fifo.sv
// Power-of-two deep 1r1w FIFO with full/empty flags; full blocks enqueue
// even when a dequeue happens in the same cycle.
module bsg_test_node_resp_fifo
  import bsg_test_node_pkg::*;
#(
  parameter int unsigned width_p = 80,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int unsigned addr_width_lp = $clog2(els_p);

  logic [width_p-1:0]     mem [els_p];
  logic [addr_width_lp:0] wr_ptr, rd_ptr;
  logic                   do_enq, do_deq;

  assign do_enq = enq_i & ~full_o;
  assign do_deq = deq_i & ~empty_o;

  // Extra MSB on the pointers distinguishes full from empty.
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[addr_width_lp] != rd_ptr[addr_width_lp])
                && (wr_ptr[addr_width_lp-1:0] == rd_ptr[addr_width_lp-1:0]);

  assign data_o = mem[rd_ptr[addr_width_lp-1:0]];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_enq) mem[wr_ptr[addr_width_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bsg_test_node_echo_client.sv
// Client test node: decodes ring packets, handles enable/disable/clear
// commands and echoes data packets back to the master with payload + 1.
module bsg_test_node_echo_client
  import bsg_test_node_pkg::*;
#(
  parameter int unsigned ring_width_p = 80,
  parameter int unsigned master_id_p  = 0,
  parameter int unsigned client_id_p  = 1,
  parameter int unsigned fifo_els_p   = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i,
  output logic                    enabled_o,
  output logic [31:0]             rx_count_o,
  output logic [31:0]             drop_count_o,
  output logic                    error_o
);

  localparam int unsigned payload_width_lp = ring_width_p - header_width_lp;
  localparam logic [destid_width_lp-1:0] master_id_lp = destid_width_lp'(master_id_p);
  localparam logic [destid_width_lp-1:0] client_id_lp = destid_width_lp'(client_id_p);
  localparam logic [payload_width_lp-1:0] payload_one_lp = {{(payload_width_lp-1){1'b0}}, 1'b1};

  logic [destid_width_lp-1:0]  destid;
  logic                        cmd;
  logic [opcode_width_lp-1:0]  opcode;
  logic [payload_width_lp-1:0] payload;

  assign destid  = data_i[ring_width_p-1 -: destid_width_lp];
  assign cmd     = data_i[ring_width_p-destid_width_lp-1];
  assign opcode  = data_i[ring_width_p-destid_width_lp-cmd_width_lp-1 -: opcode_width_lp];
  assign payload = data_i[payload_width_lp-1:0];

  state_e state, state_n;
  logic   accept, for_us;
  logic   clear, err_set, enq, drop_inc, rx_inc;
  logic   fifo_full, fifo_empty;
  logic   [ring_width_p-1:0] resp, fifo_data;

  assign for_us  = (destid == client_id_lp);
  // Gated by reset so the node never advertises ready while being cleared.
  assign ready_o = reset_n_i & ~fifo_full;
  assign accept  = v_i & ready_o;

  assign resp = {master_id_lp, 1'b0, opcode, payload + payload_one_lp};

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state <= DISABLED;
    else            state <= state_n;
  end

  always_comb begin
    state_n  = state;
    clear    = 1'b0;
    err_set  = 1'b0;
    enq      = 1'b0;
    drop_inc = 1'b0;
    rx_inc   = 1'b0;
    if (accept) begin
      if (cmd) begin
        if (for_us) begin
          case (opcode)
            cmd_enable:  state_n = ENABLED;
            cmd_disable: state_n = DISABLED;
            cmd_clear:   clear   = 1'b1;
            default:     err_set = 1'b1;
          endcase
        end
      end else if (!for_us) begin
        err_set = 1'b1;
      end else if (state == ENABLED) begin
        enq    = 1'b1;
        rx_inc = 1'b1;
      end else begin
        drop_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rx_count_o   <= '0;
      drop_count_o <= '0;
      error_o      <= 1'b0;
    end else begin
      if (clear) begin
        rx_count_o   <= '0;
        drop_count_o <= '0;
      end else begin
        if (rx_inc && (rx_count_o != '1))     rx_count_o   <= rx_count_o + 32'd1;
        if (drop_inc && (drop_count_o != '1)) drop_count_o <= drop_count_o + 32'd1;
      end
      if (err_set) error_o <= 1'b1;
    end
  end

  bsg_test_node_resp_fifo #(
    .width_p (ring_width_p),
    .els_p   (fifo_els_p)
  ) resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq_i     (enq),
    .data_i    (resp),
    .deq_i     (yumi_i & v_o),
    .data_o    (fifo_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign v_o       = ~fifo_empty;
  // Storage is not reset, so the output is forced to zero while idle.
  assign data_o    = v_o ? fifo_data : '0;
  assign enabled_o = (state == ENABLED);

endmodule

// File: doc/bsg_test_node_echo_client.md
Name: bsg_test_node_echo_client

Overview:
Client-side test node that consumes the ring packets produced by the trace-replay master and returns one response per accepted data packet.
- Decodes FSB-style packets: destination id, cmd bit, opcode, payload.
- Handles enable/disable/clear commands.
- Echoes data packets to the master with the payload incremented, buffered in a small FIFO.
- Exports sticky error and packet counters so the trace ROM can verify round trips.

Parameters:
ring_width_p, 80, packet width; must be at least 16.
master_id_p, 0, 4-bit destid placed on every response.
client_id_p, 1, 4-bit destid this node accepts.
fifo_els_p, 4, response FIFO depth; must be a power of two and at least 2.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous active-low reset
v_i  in  1  inbound packet valid
data_i  in  ring_width_p  inbound packet
ready_o  out  1  inbound ready; transfer occurs when v_i & ready_o
v_o  out  1  response valid
data_o  out  ring_width_p  response packet
yumi_i  in  1  response consumed; asserted only when v_o is high
enabled_o  out  1  node enabled state
rx_count_o  out  32  data packets echoed
drop_count_o  out  32  data packets dropped while disabled
error_o  out  1  sticky error

Behaviour:
- Packet fields (W = ring_width_p):
  - destid = [W-1:W-4]
  - cmd = [W-5]
  - opcode = [W-6:W-12]
  - payload = [W-13:0]
- Reset: reset_n_i sampled low at a clock edge clears everything on that edge:
  - FIFO flushed; v_o=0, data_o=0 (data_o is don't-care while v_o=0, but it is reset to 0).
  - enabled_o=0, both counters 0, error_o=0.
  - ready_o=0 during reset, 1 on the first cycle after release.
  - Reset mid-transfer discards queued and in-flight packets; no partial responses.
- ready_o = ~fifo_full. It is independent of packet type, so cmd and dropped packets also stall while the FIFO is full.
- Control FSM has two states, DISABLED (reset state) and ENABLED. A cmd packet (cmd=1) is processed only if destid==client_id_p:
  - opcode 7'h01: go to ENABLED.
  - opcode 7'h02: go to DISABLED.
  - opcode 7'h03: clear rx_count and drop_count; state unchanged.
  - Any other opcode: set error_o; state unchanged.
  - Cmd packets never generate a response.
  - The state change is visible on enabled_o the cycle after acceptance.
- Data packet (cmd=0):
  - destid != client_id_p: set error_o, consume the packet, no response, no count.
  - DISABLED: consume, drop_count+1.
  - ENABLED: enqueue response, rx_count+1. Response layout:
    - destid = master_id_p
    - cmd = 0
    - opcode = incoming opcode
    - payload = (incoming payload + 1) mod 2^(W-12); all-ones wraps to 0.
- Latency: a packet accepted at edge t has its response on v_o/data_o in cycle t+1 if the FIFO was empty. Output order equals acceptance order.
- FIFO:
  - Enqueue and dequeue in the same cycle are legal, including when the FIFO is non-empty and not full.
  - When full, ready_o=0. A yumi_i in that cycle makes ready_o=1 in the next cycle. There is no same-cycle bypass of full.
  - v_o = ~fifo_empty.
  - data_o holds stable while v_o=1 and yumi_i=0.
- Counters saturate at 32'hFFFF_FFFF. A clear and an increment in the same cycle cannot occur, since only one packet is accepted per cycle.
- error_o is sticky until reset.

Decomposition:
- Shared package bsg_test_node_pkg holds:
  - localparams for field widths and offsets (destid 4, cmd 1, opcode 7).
  - Opcode constants cmd_enable=7'h01, cmd_disable=7'h02, cmd_clear=7'h03.
  - A state typedef {DISABLED, ENABLED}.
- One sub-module: bsg_test_node_resp_fifo, a fifo_els_p-deep 1r1w FIFO with full/empty flags and active-low synchronous reset.

Test Plan:
- After reset, send a data packet with destid=1, opcode=5, payload=7 -> no response, drop_count_o=1, enabled_o=0.
- Send cmd enable, then a data packet with payload=7 -> enabled_o=1 the next cycle; response on the following cycle with destid=0, opcode=5, payload=8; rx_count_o=1.
- Data packet with payload all-ones -> response payload=0.
- Hold yumi_i=0 and send 5 data packets with fifo_els_p=4 -> ready_o drops after the 4th acceptance; one yumi_i re-raises ready_o the next cycle; responses come out in order with payload+1.
- Data packet with destid=3, and separately a cmd with opcode 7'h7F -> error_o=1 and stays set; no response.
- Pull reset_n_i low for one cycle with 3 responses queued -> v_o=0, counters 0, enabled_o=0 on the next cycle; no stale response afterwards.
